// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: shares one fp_unit among NREQ requesters. A round-robin
// grant picks one request, the operation is issued to the unit with a
// one-cycle enable, the unit's ready is awaited under a watchdog, and the
// result is handed back to the owning requester over a valid/ready port.
// Only one operation is ever in flight.

// Per-requester slice: opcode legality check and handshake gating.
module fp_arb_lane (
    input  logic [9:0] opcode,
    input  logic       grant,
    input  logic       serve,
    output logic       op_ok,
    output logic       req_ready,
    output logic       rsp_valid
);
    // An opcode is legal only when exactly one operation bit is set.
    assign op_ok     = (opcode != '0) && ((opcode & (opcode - 10'd1)) == '0);
    assign req_ready = grant;
    assign rsp_valid = serve;
endmodule

module fp_unit_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*209-1:0] req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [63:0]         rsp_result,
    output logic [4:0]          rsp_flags,
    output logic                fpu_enable,
    output logic [208:0]        fpu_op,
    input  logic                fpu_ready,
    input  logic [63:0]         fpu_result,
    input  logic [4:0]          fpu_flags,
    output logic                timeout
);
    localparam int              IW   = $clog2(NREQ);
    // WAIT is left on its TIMEOUT-th cycle, when the counter holds TIMEOUT-1.
    localparam logic [7:0]      WLIM = 8'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE  = NREQ'(1);

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] data3;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [1:0]  fcvt_op;
        logic [9:0]  opcode;
    } fp_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        owner, owner_n;
    logic [IW-1:0]        ptr, ptr_n;
    logic [IW-1:0]        gidx;
    logic                 any_req;
    logic                 take_req;
    fp_req_t              op_q, op_n;
    fp_req_t [NREQ-1:0]   ops;
    logic [63:0]          res_q, res_n;
    logic [4:0]           flg_q, flg_n;
    logic [7:0]           wcnt, wcnt_n;
    logic [NREQ-1:0]      lane_ok;
    logic [NREQ-1:0]      grant_oh;
    logic [NREQ-1:0]      serve_oh;

    assign ops = req_op;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        int idx;
        any_req = 1'b0;
        gidx    = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                gidx    = IW'(idx);
            end
        end
    end

    // A grant is only offered from IDLE and never while reset is held.
    assign take_req = (state == IDLE) && any_req && !reset;
    assign grant_oh = take_req ? (ONE << gidx) : '0;
    assign serve_oh = (state == RESP) ? (ONE << owner) : '0;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        fp_arb_lane u_lane (
            .opcode    (ops[i].opcode),
            .grant     (grant_oh[i]),
            .serve     (serve_oh[i]),
            .op_ok     (lane_ok[i]),
            .req_ready (req_ready[i]),
            .rsp_valid (rsp_valid[i])
        );
    end

    // Sequencer next-state, captures and single-cycle strobes.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        ptr_n      = ptr;
        op_n       = op_q;
        res_n      = res_q;
        flg_n      = flg_q;
        wcnt_n     = wcnt;
        fpu_enable = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (take_req) begin
                    op_n    = ops[gidx];
                    owner_n = gidx;
                    if (lane_ok[gidx]) begin
                        state_n = ISSUE;
                    end else begin
                        // Illegal opcode never reaches the unit: report NV.
                        res_n   = '0;
                        flg_n   = 5'b10000;
                        state_n = RESP;
                    end
                end
            end
            ISSUE: begin
                fpu_enable = 1'b1;
                wcnt_n     = '0;
                state_n    = WAIT;
            end
            WAIT: begin
                // Unit completion beats the watchdog on the limit cycle.
                if (fpu_ready) begin
                    res_n   = fpu_result;
                    flg_n   = fpu_flags;
                    state_n = RESP;
                end else if (wcnt == WLIM) begin
                    res_n   = '0;
                    flg_n   = '0;
                    timeout = 1'b1;
                    state_n = RESP;
                end else begin
                    wcnt_n = wcnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready[owner]) begin
                    ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and capture registers; reset drops any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            op_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            op_q  <= op_n;
            res_q <= res_n;
            flg_q <= flg_n;
            wcnt  <= wcnt_n;
        end
    end

    assign fpu_op     = op_q;
    assign rsp_result = (state == RESP) ? res_q : '0;
    assign rsp_flags  = (state == RESP) ? flg_q : '0;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: directed steps, a behavioural unit model with
// programmable latency, and a scoreboard of expected responses.
module tb_fp_unit_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 4;

    typedef logic [208:0] v_t;

    typedef struct {
        int          owner;
        logic [208:0] op;
        logic [63:0] res;
        logic [4:0]  flg;
        int          rcyc;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*209-1:0] req_op = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [63:0]         rsp_result;
    logic [4:0]          rsp_flags;
    logic                fpu_enable;
    logic [208:0]        fpu_op;
    logic                mdl_ready = 1'b0;
    logic                stim_ready = 1'b0;
    wire                 fpu_ready = mdl_ready | stim_ready;
    logic [63:0]         fpu_result = '0;
    logic [4:0]          fpu_flags = '0;
    logic                timeout;

    fp_unit_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .fpu_enable(fpu_enable), .fpu_op(fpu_op),
        .fpu_ready(fpu_ready), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt++;

    int n_tests = 0, n_fail = 0;
    int n_en = 0, n_to = 0, n_acc = 0, n_rsp = 0;
    int exp_ptr = 0, acc_cyc = 0;
    bit busy = 0;
    exp_t sb[$];
    int grants[$];
    logic [NREQ-1:0] prev_v = '0;

    // Unit model: {flags, result} for an operation.
    function automatic logic [68:0] unit_fn(input logic [208:0] op);
        logic [63:0] r;
        if (op[9:0] == 10'h002 && op[208:145] == 64'h3F800000 && op[144:81] == 64'h40000000)
            return {5'b0, 64'h40400000};
        r = op[208:145] ^ (op[144:81] << 1) ^ op[80:17] ^ {54'b0, op[9:0]};
        return {op[14:12], op[16:15], r};
    endfunction

    int mdl_cnt = 0, mdl_lat = 2;
    bit mdl_hang = 0;
    logic [208:0] mdl_op = '0;

    // Unit model: ready mdl_lat cycles after the enable; junk otherwise.
    always @(negedge clock) begin
        mdl_ready  = 1'b0;
        fpu_result = 64'hBAD0_BAD0_BAD0_BAD0;
        fpu_flags  = 5'h1F;
        if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0 && !mdl_hang) begin
                mdl_ready = 1'b1;
                {fpu_flags, fpu_result} = unit_fn(mdl_op);
            end
        end
        if (fpu_enable) begin
            mdl_cnt = mdl_lat;
            mdl_op  = fpu_op;
        end
    end

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] m = '0;
        if (i >= 0 && i < NREQ) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int exp_grant();
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (exp_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] d3, input logic [1:0] fmt,
                          input logic [2:0] rm, input logic [9:0] opc);
        req_op[i*209 +: 209] = {d1, d2, d3, fmt, rm, 2'b00, opc};
    endtask

    // Monitor for one cycle: grants, enables, responses against scoreboard.
    task automatic sample();
        exp_t e;
        int g;
        logic [9:0] opc;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clock); #1;
        g = exp_grant();
        exp_rdy = (busy || reset) ? '0 : oh(g);
        chk("req_ready", v_t'(req_ready), v_t'(exp_rdy));
        if (req_ready != '0 && g >= 0) begin
            e.owner = g;
            e.op    = req_op[g*209 +: 209];
            opc     = e.op[9:0];
            if (opc == '0 || (opc & (opc - 10'd1)) != '0) begin
                e.res = '0; e.flg = 5'h10; e.rcyc = cyc_cnt + 1;
            end else if (mdl_hang || mdl_lat > TMO) begin
                e.res = '0; e.flg = '0; e.rcyc = cyc_cnt + 2 + TMO;
            end else begin
                {e.flg, e.res} = unit_fn(e.op);
                e.rcyc = cyc_cnt + 2 + mdl_lat;
            end
            sb.push_back(e);
            busy = 1; acc_cyc = cyc_cnt; grants.push_back(g); n_acc++;
        end
        if (fpu_enable) begin
            n_en++;
            chk("en_cycle", v_t'(cyc_cnt), v_t'(acc_cyc + 1));
            if (sb.size() > 0) chk("fpu_op", fpu_op, sb[$].op);
        end
        if (timeout) n_to++;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", v_t'(rsp_valid), v_t'(0));
            end else begin
                e = sb[0];
                chk("rsp_valid", v_t'(rsp_valid), v_t'(oh(e.owner)));
                if (prev_v == '0) chk("rsp_cycle", v_t'(cyc_cnt), v_t'(e.rcyc));
                chk("rsp_result", v_t'(rsp_result), v_t'(e.res));
                chk("rsp_flags", v_t'(rsp_flags), v_t'(e.flg));
                if ((rsp_valid & rsp_ready) != '0) begin
                    void'(sb.pop_front());
                    busy = 0; exp_ptr = (e.owner + 1) % NREQ; n_rsp++;
                end
            end
        end else begin
            chk("rsp_idle_zero", v_t'({rsp_result, rsp_flags}), v_t'(0));
        end
        prev_v = rsp_valid;
    endtask

    task automatic advance();
        @(posedge clock); #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, v_t'(req_ready), v_t'(0));
        chk({tag, "_rsp_valid"}, v_t'(rsp_valid), v_t'(0));
        chk({tag, "_rsp_result"}, v_t'(rsp_result), v_t'(0));
        chk({tag, "_rsp_flags"}, v_t'(rsp_flags), v_t'(0));
        chk({tag, "_fpu_enable"}, v_t'(fpu_enable), v_t'(0));
        chk({tag, "_fpu_op"}, fpu_op, v_t'(0));
        chk({tag, "_timeout"}, v_t'(timeout), v_t'(0));
    endtask

    task automatic wait_acc(input int budget);
        int n0 = n_acc;
        for (int i = 0; i < budget && n_acc == n0; i++) step();
        chk("accept_seen", v_t'(n_acc != n0), v_t'(1));
    endtask

    task automatic wait_rsp(input int budget);
        int n0 = n_rsp;
        for (int i = 0; i < budget && n_rsp == n0; i++) step();
        chk("response_seen", v_t'(n_rsp != n0), v_t'(1));
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) step();
        chk("drained", v_t'(sb.size()), v_t'(0));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, g0;
        // Reset state.
        sample(); chk_zero("reset"); advance();
        step();
        reset = 1'b0;

        // Round robin with all requesters active.
        mdl_lat = 2;
        for (int i = 0; i < NREQ; i++)
            set_op(i, 64'(i + 1) * 64'h1111, 64'(i + 3), 64'h55, 2'(i), 3'(i), 10'(1 << i));
        req_valid = '1; rsp_ready = '1;
        for (int i = 0; i < 100 && grants.size() < 5; i++) step();
        chk("rr_count", v_t'(grants.size() >= 5), v_t'(1));
        chk("rr_g0", v_t'(grants[0]), v_t'(0));
        chk("rr_g1", v_t'(grants[1]), v_t'(1));
        chk("rr_g2", v_t'(grants[2]), v_t'(2));
        chk("rr_g3", v_t'(grants[3]), v_t'(3));
        chk("rr_g4", v_t'(grants[4]), v_t'(0));
        // Stall requester 2's response for several cycles.
        rsp_ready = 4'b1011;
        for (int i = 0; i < 100 && !prev_v[2]; i++) step();
        chk("stall_reached", v_t'(prev_v), v_t'(4'b0100));
        g0 = grants.size();
        for (int i = 0; i < 5; i++) step();
        chk("stall_no_grant", v_t'(grants.size()), v_t'(g0));
        chk("stall_held", v_t'(prev_v), v_t'(4'b0100));
        rsp_ready = '1; req_valid = '0;
        wait_drain(50);

        // Single fadd on requester 0.
        mdl_lat = 3; n0 = n_en;
        set_op(0, 64'h3F800000, 64'h40000000, 64'h0, 2'd0, 3'd0, 10'h002);
        req_valid = 4'b0001; rsp_ready = 4'b0001;
        wait_acc(20); req_valid = '0;
        wait_rsp(30);
        chk("fadd_enables", v_t'(n_en - n0), v_t'(1));

        // Illegal opcode on requester 1.
        n0 = n_en;
        set_op(1, 64'h1234, 64'h5678, 64'h9, 2'd1, 3'd2, 10'h006);
        req_valid = 4'b0010; rsp_ready = '1;
        wait_acc(20); req_valid = '0;
        wait_rsp(20);
        chk("invalid_no_enable", v_t'(n_en - n0), v_t'(0));

        // Watchdog abort with a silent unit.
        mdl_hang = 1; n0 = n_to;
        set_op(2, 64'hABCD, 64'h1, 64'h2, 2'd1, 3'd1, 10'h010);
        req_valid = 4'b0100;
        wait_acc(20); req_valid = '0;
        wait_rsp(TMO + 20);
        chk("timeout_pulses", v_t'(n_to - n0), v_t'(1));
        // Next request completes normally.
        mdl_hang = 0; mdl_lat = 1; n0 = n_to;
        set_op(3, 64'h77, 64'h88, 64'h99, 2'd0, 3'd3, 10'h020);
        req_valid = 4'b1000;
        wait_acc(20); req_valid = '0;
        wait_rsp(20);
        chk("after_timeout_no_pulse", v_t'(n_to - n0), v_t'(0));
        // Ready on the limit cycle wins over the watchdog.
        mdl_lat = TMO; n0 = n_to;
        set_op(0, 64'hFEED, 64'hBEEF, 64'h3, 2'd1, 3'd4, 10'h200);
        req_valid = 4'b0001;
        wait_acc(20); req_valid = '0;
        wait_rsp(TMO + 20);
        chk("limit_no_pulse", v_t'(n_to - n0), v_t'(0));

        // Stale ready in IDLE.
        n0 = n_rsp;
        stim_ready = 1'b1; step(); stim_ready = 1'b0;
        step(); step();
        chk("stale_idle", v_t'(n_rsp - n0), v_t'(0));
        // Stale ready while a response is held.
        mdl_lat = 2; rsp_ready = '0;
        set_op(0, 64'h4242, 64'h2424, 64'h11, 2'd0, 3'd1, 10'h008);
        req_valid = 4'b0001;
        wait_acc(20); req_valid = '0;
        for (int i = 0; i < 30 && !prev_v[0]; i++) step();
        chk("stale_resp_reached", v_t'(prev_v), v_t'(4'b0001));
        stim_ready = 1'b1; step(); stim_ready = 1'b0;
        step();
        rsp_ready = '1;
        wait_drain(20);

        // Reset in WAIT abandons the operation; the late ready is ignored.
        mdl_lat = TMO; n0 = n_rsp;
        set_op(2, 64'h1357, 64'h2468, 64'h5, 2'd0, 3'd0, 10'h040);
        req_valid = 4'b0100;
        wait_acc(20); req_valid = '0;
        step();
        reset = 1'b1;
        sb.delete(); busy = 0; exp_ptr = 0;
        step();
        reset = 1'b0;
        sample(); chk_zero("midreset"); advance();
        for (int i = 0; i < 8; i++) step();
        chk("late_ready_ignored", v_t'(n_rsp - n0), v_t'(0));
        // First grant after reset goes to requester 0.
        mdl_lat = 1;
        req_valid = '1;
        wait_acc(20); req_valid = '0;
        chk("post_reset_grant", v_t'(grants[$]), v_t'(0));
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Round-robin arbiter and sequencer that shares one `fp_unit` instance among `NREQ` requesters. It accepts one operation at a time over a valid/ready request port and drives it onto the unit with a single-cycle enable. It then waits for the unit's ready, with a watchdog, and returns result and flags to the owning requester over a valid/ready response port. It sits between core-side FP issue ports and `fp_unit`.

## Interface
- `NREQ`, 2: number of requesters, legal 2..8.
- `TIMEOUT`, 63: maximum WAIT cycles before abort, legal 1..255.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: request valid per requester.
- `req_ready` out NREQ: request accepted, one-hot or zero.
- `req_op` in NREQ*209: per-requester slice; within each slice:
  - [208:145] data1, [144:81] data2, [80:17] data3
  - [16:15] fmt, [14:12] rm, [11:10] fcvt_op
  - [9:0] opcode, one-hot:
    - bit0 fmadd, 1 fadd, 2 fsub, 3 fmul, 4 fdiv
    - bit5 fsqrt, 6 fcmp, 7 fcvt_f2f, 8 fcvt_i2f, 9 fcvt_f2i
- `rsp_valid` out NREQ: response valid, one-hot or zero.
- `rsp_ready` in NREQ: response accepted per requester.
- `rsp_result` out 64: result, meaningful when any `rsp_valid`.
- `rsp_flags` out 5: NV,DZ,OF,UF,NX (bit4..0).
- `fpu_enable` out 1: one-cycle issue strobe to `fp_unit`.
- `fpu_op` out 209: captured operation, same layout as a `req_op` slice.
- `fpu_ready` in 1: unit result valid.
- `fpu_result` in 64, `fpu_flags` in 5: unit outputs.
- `timeout` out 1: one-cycle pulse on watchdog abort.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP. Registers:
  - `owner`: index of requester being served.
  - `ptr`: round-robin pointer.
  - `op_q`: captured operation.
  - `res_q`, `flg_q`: captured result and flags.
  - `wcnt`: 8-bit WAIT counter.
- IDLE:
  - Grant g = first index with `req_valid` set, searching from `ptr` upward with wrap modulo NREQ.
  - `req_ready[g]`=1 combinationally, in the same cycle only. Capture `req_op[g]` into `op_q` and set `owner`=g.
  - If opcode is exactly one-hot, go to ISSUE.
  - Otherwise (zero or multiple bits set), the unit is never enabled: load `res_q`=0, `flg_q`=5'b10000, and go to RESP.
- ISSUE: `fpu_enable`=1 for exactly this cycle; clear `wcnt`; go to WAIT.
- WAIT:
  - `fpu_ready`=1: capture `fpu_result` and `fpu_flags`, then go to RESP.
  - Otherwise increment `wcnt`. When `wcnt` reaches TIMEOUT: load `res_q`=0, `flg_q`=0, pulse `timeout`, and go to RESP.
  - `fpu_ready` takes priority if it arrives in the same cycle as the limit.
- RESP:
  - `rsp_valid[owner]`=1, with `rsp_result`=`res_q` and `rsp_flags`=`flg_q`, held stable until `rsp_ready[owner]`.
  - On acceptance: `ptr`=(owner+1) mod NREQ, then go to IDLE.
- `fpu_op` is driven from `op_q` continuously. It is stable from ISSUE through RESP.
- `fpu_ready` is ignored outside WAIT, so a stale completion is never forwarded.
- `req_ready` is 0 in every state except IDLE. Only one operation is ever in flight.
- `rsp_ready` of non-owners, and `rsp_ready` outside RESP, are ignored.
- `rsp_result` and `rsp_flags` are 0 whenever no `rsp_valid` is set.

## Timing
- Reset values:
  - State IDLE; `ptr`=0; `owner`=0.
  - `op_q`, `res_q`, `flg_q`, `wcnt` all 0.
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_result`, `rsp_flags`, `fpu_enable`, `fpu_op`, `timeout`.
- Reset mid-operation abandons the in-flight operation; no response is produced. A unit completion after reset is ignored.
- Accept at cycle t. Then:
  - `fpu_enable` asserts at t+1.
  - With `fpu_ready` at t+1+L (L≥1), `rsp_valid` asserts at t+2+L.
  - Response accepted at cycle r: next grant earliest at r+1.
- Invalid opcode: `rsp_valid` at t+1.
- Timeout path: `fpu_enable` at t+1, WAIT begins at t+2, and `rsp_valid` asserts TIMEOUT cycles after WAIT entry.
- Fairness: a continuously requesting requester waits at most NREQ-1 other operations.

## Test plan
- Single fadd, req 0: data1=0x3F800000, data2=0x40000000, fmt=0, rm=0, opcode=0x002, with a real `fp_unit`.
  - `fpu_enable` exactly one cycle, one cycle after accept.
  - `rsp_valid`=2'b01, `rsp_result`=0x40400000, `rsp_flags`=0.
- Round robin, NREQ=4, all `req_valid` held high, each `rsp_ready` immediate.
  - Grant order 0,1,2,3,0.
  - Insert a response stall of 5 cycles on requester 2: `rsp_valid` and outputs are held, and no grant occurs during the stall.
- Invalid opcode 0x006 on req 1:
  - `fpu_enable` never asserts.
  - Response at t+1: result 0, flags 0x10.
- Timeout, TIMEOUT=4, with the unit model never asserting ready:
  - One `timeout` pulse.
  - Response result 0, flags 0.
  - Next request served normally.
  - Repeat with `fpu_ready` arriving exactly on the limit cycle: the unit result wins and there is no `timeout` pulse.
- Stale ready and reset:
  - `fpu_ready` pulsed in IDLE and in RESP has no effect.
  - Assert `reset` during WAIT: all outputs 0 next cycle, and a late `fpu_ready` produces no `rsp_valid`.
  - First grant after reset goes to requester 0.
